// File: rtl/seq_comparator_if.sv
// Request/result bundle for seq_comparator.
// The slave modport is the comparator's view. The master modport is the view of
// the block that issues requests and takes the results.
interface seq_comparator_if #(
    parameter int WIDTH = 32
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_signed;
    logic             i_clear;
    logic             o_valid;
    logic             i_ready;
    logic             o_lt;
    logic             o_eq;
    logic             o_gt;

    modport slave (
        input  i_valid, i_a, i_b, i_signed, i_clear, i_ready,
        output o_ready, o_valid, o_lt, o_eq, o_gt
    );

    modport master (
        output i_valid, i_a, i_b, i_signed, i_clear, i_ready,
        input  o_ready, o_valid, o_lt, o_eq, o_gt
    );
endinterface

// File: rtl/seq_comparator.sv
// Sequential magnitude comparator that works MSB-first, one SLICE-bit slice per cycle.
// Signed operands have their sign bit flipped when the request is captured.
// After that flip, an unsigned slice compare gives the two's-complement ordering.
// With EARLY_EXIT=1 the comparator finishes at the first differing slice.
// With EARLY_EXIT=0 it always walks every slice, so the latency is fixed.
module seq_comparator #(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    seq_comparator_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
            $error("seq_comparator: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    // Fixed-latency mode: the first differing slice records its verdict here.
    logic               found_q, found_d;
    logic               flt_q, flt_d;
    // Held low through reset so that o_ready rises only at the first edge after release.
    logic               armed_q;
    logic [SLICE-1:0]   sa, sb;

    // Flips the MSB for a signed request, which maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v, input logic s);
        logic [WIDTH-1:0] m;
        m            = '0;
        m[WIDTH-1]   = s;
        return v ^ m;
    endfunction

    // Returns slice j of v.
    function automatic logic [SLICE-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                  input logic [IDX_W-1:0] j);
        return SLICE'(v >> (int'(j) * SLICE));
    endfunction

    assign sa          = slice_of(a_q, idx_q);
    assign sb          = slice_of(b_q, idx_q);
    assign bus.o_ready = armed_q && (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_lt    = lt_q;
    assign bus.o_eq    = eq_q;
    assign bus.o_gt    = gt_q;

    // Next-state and next-datapath logic; i_clear overrides every other transition.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        found_d = found_q;
        flt_d   = flt_q;

        if (bus.i_clear) begin
            state_d = IDLE;
            lt_d    = 1'b0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
            found_d = 1'b0;
            flt_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && armed_q) begin
                        a_d     = bias(bus.i_a, bus.i_signed);
                        b_d     = bias(bus.i_b, bus.i_signed);
                        idx_d   = IDX_W'(NSLICE - 1);
                        lt_d    = 1'b0;
                        eq_d    = 1'b0;
                        gt_d    = 1'b0;
                        found_d = 1'b0;
                        flt_d   = 1'b0;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (EARLY_EXIT != 0) begin
                        if (sa != sb) begin
                            lt_d    = (sa < sb);
                            gt_d    = (sa > sb);
                            state_d = DONE;
                        end else if (idx_q == '0) begin
                            eq_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end else begin
                        if (!found_q && (sa != sb)) begin
                            found_d = 1'b1;
                            flt_d   = (sa < sb);
                        end
                        if (idx_q == '0) begin
                            state_d = DONE;
                            if (found_q) begin
                                lt_d = flt_q;
                                gt_d = !flt_q;
                            end else if (sa != sb) begin
                                lt_d = (sa < sb);
                                gt_d = (sa > sb);
                            end else begin
                                eq_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset asynchronously discards any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            found_q <= 1'b0;
            flt_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            found_q <= found_d;
            flt_q   <= flt_d;
            armed_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator. Four configurations are driven in lockstep from shared stimulus:
// 32/8 early exit, 32/8 fixed latency, 16/4 early exit, and 32/32 early exit.
module tb_seq_comparator;
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sgn = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_comparator_if #(.WIDTH(32)) if0 ();
    seq_comparator_if #(.WIDTH(32)) if1 ();
    seq_comparator_if #(.WIDTH(16)) if2 ();
    seq_comparator_if #(.WIDTH(32)) if3 ();

    assign if0.i_valid = valid; assign if0.i_a = a; assign if0.i_b = b;
    assign if0.i_signed = sgn; assign if0.i_clear = clr; assign if0.i_ready = rdy;
    assign if1.i_valid = valid; assign if1.i_a = a; assign if1.i_b = b;
    assign if1.i_signed = sgn; assign if1.i_clear = clr; assign if1.i_ready = rdy;
    assign if2.i_valid = valid; assign if2.i_a = a[15:0]; assign if2.i_b = b[15:0];
    assign if2.i_signed = sgn; assign if2.i_clear = clr; assign if2.i_ready = rdy;
    assign if3.i_valid = valid; assign if3.i_a = a; assign if3.i_b = b;
    assign if3.i_signed = sgn; assign if3.i_clear = clr; assign if3.i_ready = rdy;

    seq_comparator #(.WIDTH(32), .SLICE(8),  .EARLY_EXIT(1)) d0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
    seq_comparator #(.WIDTH(32), .SLICE(8),  .EARLY_EXIT(0)) d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
    seq_comparator #(.WIDTH(16), .SLICE(4),  .EARLY_EXIT(1)) d2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
    seq_comparator #(.WIDTH(32), .SLICE(32), .EARLY_EXIT(1)) d3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));

    logic [3:0] vld, rdyo;
    logic [2:0] res [4];
    assign vld  = {if3.o_valid, if2.o_valid, if1.o_valid, if0.o_valid};
    assign rdyo = {if3.o_ready, if2.o_ready, if1.o_ready, if0.o_ready};
    assign res[0] = {if0.o_lt, if0.o_eq, if0.o_gt};
    assign res[1] = {if1.o_lt, if1.o_eq, if1.o_gt};
    assign res[2] = {if2.o_lt, if2.o_eq, if2.o_gt};
    assign res[3] = {if3.o_lt, if3.o_eq, if3.o_gt};

    int          cfg_w  [4] = '{32, 32, 16, 32};
    int          cfg_sl [4] = '{8, 8, 4, 32};
    bit          cfg_ee [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          m_lat  [4];
    logic [2:0]  m_res  [4];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [2:0]  res;
        int          lat;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                           input int w, input bit s);
        longint vx, vy;
        if (w == 16) begin
            vx = s ? longint'($signed(x[15:0])) : longint'(x[15:0]);
            vy = s ? longint'($signed(y[15:0])) : longint'(y[15:0]);
        end else begin
            vx = s ? longint'($signed(x)) : longint'(x);
            vy = s ? longint'($signed(y)) : longint'(y);
        end
        if (vx < vy) return LT;
        if (vx == vy) return EQ;
        return GT;
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y,
                                   input int w, input int sl, input bit ee);
        int          n;
        logic [63:0] mask;
        n    = w / sl;
        mask = (64'd1 << sl) - 64'd1;
        if (!ee) return n;
        for (int j = n - 1; j >= 0; j--) begin
            if (((64'(x) >> (j * sl)) & mask) != ((64'(y) >> (j * sl)) & mask)) return n - j;
        end
        return n;
    endfunction

    // Issues one request to all DUTs, records per-DUT latency and result, then completes the handshake.
    task automatic run(input logic [31:0] ta, input logic [31:0] tb_, input bit ts);
        @(negedge clk);
        valid = 1'b1; a = ta; b = tb_; sgn = ts; rdy = 1'b0;
        check("accept_ready", 32'(rdyo), 32'hF);
        @(posedge clk); #1;
        valid = 1'b0; a = ~ta; b = ~tb_; sgn = ~ts;
        for (int k = 0; k < 4; k++) begin m_lat[k] = 0; m_res[k] = 3'b000; end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                if (vld[k] && m_lat[k] == 0) begin m_lat[k] = c; m_res[k] = res[k]; end
            if (m_lat[0] != 0 && m_lat[1] != 0 && m_lat[2] != 0 && m_lat[3] != 0) break;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("held_d%0d", k), {29'd0, res[k]}, {29'd0, m_res[k]});
        @(negedge clk); rdy = 1'b1;
        @(posedge clk); #1; rdy = 1'b0;
        check("post_hs_valid", 32'(vld), 32'h0);
    endtask

    task automatic chk_ref(input logic [31:0] ta, input logic [31:0] tb_, input bit ts);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("res_d%0d %h/%h s%0d", k, ta, tb_, ts), {29'd0, m_res[k]},
                  {29'd0, ref_res(ta, tb_, cfg_w[k], ts)});
            check($sformatf("lat_d%0d %h/%h", k, ta, tb_), m_lat[k],
                  ref_lat(ta, tb_, cfg_w[k], cfg_sl[k], cfg_ee[k]));
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        bit rs;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, LT, 1};
        tbl[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, GT, 1};
        tbl[2]  = '{32'h12345678, 32'h12345678, 1'b0, EQ, 4};
        tbl[3]  = '{32'h80000000, 32'h00000000, 1'b1, LT, 1};
        tbl[4]  = '{32'h00000010, 32'h00000011, 1'b0, LT, 4};
        tbl[5]  = '{32'h00000010, 32'h00000011, 1'b1, LT, 4};
        tbl[6]  = '{32'h00010000, 32'h00020000, 1'b0, LT, 2};
        tbl[7]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, GT, 1};
        tbl[8]  = '{32'h7FFFFFFF, 32'h80000000, 1'b0, LT, 1};
        tbl[9]  = '{32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, LT, 4};
        tbl[10] = '{32'h00001200, 32'h00001100, 1'b0, GT, 3};
        tbl[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, EQ, 4};
        tbl[12] = '{32'h01000000, 32'h00FFFFFF, 1'b0, GT, 1};

        // Reset state
        #12;
        check("rst_valid", 32'(vld), 32'h0);
        check("rst_ready", 32'(rdyo), 32'h0);
        check("rst_res0", {29'd0, res[0]}, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("ready_before_edge", 32'(rdyo), 32'h0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(rdyo), 32'hF);
        repeat (2) @(posedge clk); #1;
        check("idle_no_valid", 32'(vld), 32'h0);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run(tbl[i].a, tbl[i].b, tbl[i].s);
            check($sformatf("vec%0d_res_d0", i), {29'd0, m_res[0]}, {29'd0, tbl[i].res});
            check($sformatf("vec%0d_lat_d0", i), m_lat[0], tbl[i].lat);
            check($sformatf("vec%0d_res_d1", i), {29'd0, m_res[1]}, {29'd0, tbl[i].res});
            check($sformatf("vec%0d_lat_d1", i), m_lat[1], 4);
            check($sformatf("vec%0d_lat_d3", i), m_lat[3], 1);
            check($sformatf("vec%0d_res_d2", i), {29'd0, m_res[2]},
                  {29'd0, ref_res(tbl[i].a, tbl[i].b, 16, tbl[i].s)});
        end

        // Random operands, with shared upper bytes so that deeper slices get exercised
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? ra ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
            if (i % 4 == 1) rb = ra;
            rs = 1'(i % 2);
            run(ra, rb, rs);
            chk_ref(ra, rb, rs);
            for (int k = 0; k < 4; k++)
                check($sformatf("onehot_d%0d", k), $countones(m_res[k]), 1);
        end

        // Backpressure: the result is held and a pending request waits for the handshake
        @(negedge clk); valid = 1'b1; a = 32'h1; b = 32'h1; sgn = 1'b0; rdy = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (vld[0]) begin n = c; break; end
        end
        check("bp_lat", n, 4);
        @(negedge clk); valid = 1'b1; a = 32'h9; b = 32'h2;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(vld[0]), 32'h1);
            check("bp_res_held", {29'd0, res[0]}, {29'd0, EQ});
            check("bp_not_ready", 32'(rdyo[0]), 32'h0);
        end
        @(negedge clk); rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", 32'(vld[0]), 32'h0);
        check("bp_hs_ready", 32'(rdyo[0]), 32'h1);
        @(negedge clk); rdy = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        check("bp_accepted", 32'(rdyo[0]), 32'h0);
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (vld[0]) begin n = c; break; end
        end
        check("bp_next_lat", n, 4);
        check("bp_next_res", {29'd0, res[0]}, {29'd0, GT});
        @(negedge clk); rdy = 1'b1;
        @(posedge clk); #1; rdy = 1'b0;
        check("bp_drain", 32'(vld), 32'h0);

        // Clear at E0+2 of an equal-operand request
        @(negedge clk); valid = 1'b1; a = 32'h55; b = 32'h55; sgn = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        @(posedge clk);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        check("clr_valid", 32'(vld), 32'h0);
        check("clr_res0", {29'd0, res[0]}, 32'h0);
        check("clr_res3", {29'd0, res[3]}, 32'h0);
        check("clr_ready", 32'(rdyo), 32'hF);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("clr_no_valid", 32'(vld), 32'h0);
        end

        // Asynchronous reset mid-compare
        @(negedge clk); valid = 1'b1; a = 32'h77; b = 32'h77;
        @(posedge clk); #1; valid = 1'b0;
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check("arst_valid", 32'(vld), 32'h0);
        check("arst_ready", 32'(rdyo), 32'h0);
        check("arst_res3", {29'd0, res[3]}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_ready_after", 32'(rdyo), 32'hF);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("arst_no_valid", 32'(vld), 32'h0);
        end

        // The comparator still works after the reset
        run(32'hFFFFFFFF, 32'h00000001, 1'b1);
        chk_ref(32'hFFFFFFFF, 32'h00000001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
